// File: rtl/rgb_step_sequencer_pkg.sv
// Shared types and constants for the RGB step sequencer.
// Package name: rgb_seq_pkg. Optional PWM dimming is selected with RGB_SEQ_PWM_EN.
package rgb_seq_pkg;

  // Sequencer states; the two spare encodings fall back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01
  } state_e;

  // One colour step, bit order {r,g,b} as stored in the colour table.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam rgb_t RGB_OFF   = 3'b000;
  localparam rgb_t RGB_RED   = 3'b100;
  localparam rgb_t RGB_GREEN = 3'b010;
  localparam rgb_t RGB_BLUE  = 3'b001;

  // Width of a step index for a given step count (at least one bit).
  function automatic int step_width(input int num_steps);
    return (num_steps > 1) ? $clog2(num_steps) : 1;
  endfunction

endpackage

// File: rtl/rgb_step_sequencer_if.sv
// Button/config inputs and LED/status outputs of the RGB step sequencer.
// The master side drives the controls; the slave side is the sequencer.
interface rgb_step_sequencer_if #(
  parameter int NUM_STEPS = 3,
  parameter int DWELL_W   = 4,
  parameter int PWM_W     = 4
);
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  logic                   button;
  logic                   abort;
  logic                   loop_mode;
  logic [DWELL_W-1:0]     dwell;
  logic [3*NUM_STEPS-1:0] colour_table;
  logic [PWM_W-1:0]       duty;

  logic                   red;
  logic                   green;
  logic                   blue;
  logic                   busy;
  logic [STEP_W-1:0]      step_idx;
  logic                   done;

  modport master (
    output button, abort, loop_mode, dwell, colour_table, duty,
    input  red, green, blue, busy, step_idx, done
  );

  modport slave (
    input  button, abort, loop_mode, dwell, colour_table, duty,
    output red, green, blue, busy, step_idx, done
  );

endinterface

// File: rtl/rgb_step_sequencer_pwm.sv
// PWM dimmer for the sequencer LEDs: free-running counter and registered gating.
// Only compiled when RGB_SEQ_PWM_EN is defined.
`ifdef RGB_SEQ_PWM_EN
module rgb_pwm
  import rgb_seq_pkg::*;
#(
  parameter int PWM_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  rgb_t             colour,
  input  logic [PWM_W-1:0] duty,
  output rgb_t             led
);

  logic [PWM_W-1:0] pwm_cnt_q;
  rgb_t             led_q;

  // Free-running PWM counter, also runs while the sequencer is idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
  end

  // Gate each colour bit by the duty window; duty=0 keeps LEDs dark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 led_q <= RGB_OFF;
    else if (pwm_cnt_q < duty) led_q <= colour;
    else                       led_q <= RGB_OFF;
  end

  assign led = led_q;

endmodule
`endif

// File: rtl/rgb_step_sequencer.sv
// Button-triggered RGB step sequencer: NUM_STEPS colour steps with a
// programmable dwell, one-shot or looping, abortable at any time.
// Define RGB_SEQ_PWM_EN to add PWM dimming (one extra cycle on red/green/blue).
module rgb_step_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int NUM_STEPS = 3,
  parameter int DWELL_W   = 4,
  parameter int PWM_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  rgb_step_sequencer_if.slave bus
);

  localparam int STEP_W = step_width(NUM_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_e             state_q;
  logic               button_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               loop_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [STEP_W-1:0]  step_q;
  rgb_t               colour_q;
  logic               busy_q;
  logic               done_q;
  logic               start;
  rgb_t               led;

  // Colour of step idx, read live from the table at step entry.
  function automatic rgb_t colour_at(input logic [3*NUM_STEPS-1:0] tbl,
                                     input logic [STEP_W-1:0]      idx);
    return rgb_t'(tbl[3*int'(idx) +: 3]);
  endfunction

  assign start = bus.button & ~button_q;

  // Sequencer FSM; all status and colour outputs are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      button_q <= 1'b0;
      dwell_q  <= '0;
      loop_q   <= 1'b0;
      cnt_q    <= '0;
      step_q   <= '0;
      colour_q <= RGB_OFF;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      button_q <= bus.button;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q    <= '0;
          step_q   <= '0;
          colour_q <= RGB_OFF;
          busy_q   <= 1'b0;
          // abort held while idle suppresses a start
          if (start && !bus.abort) begin
            state_q  <= RUN;
            dwell_q  <= bus.dwell;
            loop_q   <= bus.loop_mode;
            colour_q <= colour_at(bus.colour_table, '0);
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            // abort wins over step advance and wrap, and never pulses done
            state_q  <= IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            colour_q <= RGB_OFF;
            busy_q   <= 1'b0;
          end else if (cnt_q == dwell_q) begin
            cnt_q <= '0;
            if (step_q != LAST_STEP) begin
              step_q   <= step_q + STEP_W'(1);
              colour_q <= colour_at(bus.colour_table, step_q + STEP_W'(1));
            end else if (loop_q) begin
              step_q   <= '0;
              colour_q <= colour_at(bus.colour_table, '0);
            end else begin
              state_q  <= IDLE;
              step_q   <= '0;
              colour_q <= RGB_OFF;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + DWELL_W'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          step_q   <= '0;
          colour_q <= RGB_OFF;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef RGB_SEQ_PWM_EN
  rgb_pwm #(
    .PWM_W (PWM_W)
  ) u_pwm (
    .clk    (clk),
    .reset  (reset),
    .colour (colour_q),
    .duty   (bus.duty),
    .led    (led)
  );
`else
  logic [PWM_W-1:0] unused_duty;
  assign unused_duty = bus.duty;
  assign led         = colour_q;
`endif

  assign bus.red      = led.r;
  assign bus.green    = led.g;
  assign bus.blue     = led.b;
  assign bus.busy     = busy_q;
  assign bus.step_idx = step_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_rgb_step_sequencer.sv
// Testbench for rgb_step_sequencer: directed scenarios with literal
// expectations plus a cycle-time model compared on every clock.
module tb_rgb_step_sequencer;
  import rgb_seq_pkg::*;

  localparam int NUM_STEPS = 3;
  localparam int DWELL_W   = 4;
  localparam int PWM_W     = 4;
  localparam int STEP_W    = $clog2(NUM_STEPS);
  localparam logic [8:0] TBL_STD = 9'b001_010_100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rgb_step_sequencer_if #(.NUM_STEPS(NUM_STEPS), .DWELL_W(DWELL_W), .PWM_W(PWM_W)) bus ();

  rgb_step_sequencer #(.NUM_STEPS(NUM_STEPS), .DWELL_W(DWELL_W), .PWM_W(PWM_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] rgb_now();
    return {bus.red, bus.green, bus.blue};
  endfunction

  // ---------------- behavioural model: time since start ----------------
  bit         m_valid = 0;
  bit         m_run, m_bq, m_loop, m_done;
  int         m_t, m_len, m_s;
  logic [2:0] m_rgb;
  int         m_step;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_run = 0; m_bq = 0; m_loop = 0; m_done = 0;
      m_t = 0; m_len = 1; m_rgb = 3'b000; m_step = 0;
    end else if (m_valid) begin
      logic [8:0] tbl;
      bit start;
      tbl    = bus.colour_table;
      start  = bus.button && !m_bq;
      m_bq   = bus.button;
      m_done = 0;
      if (m_run) begin
        if (bus.abort) begin
          m_run = 0; m_rgb = 3'b000; m_step = 0;
        end else begin
          m_t++;
          m_s = m_t / m_len;
          if (m_s >= NUM_STEPS && !m_loop) begin
            m_run = 0; m_rgb = 3'b000; m_step = 0; m_done = 1;
          end else begin
            m_step = m_s % NUM_STEPS;
            if (m_t % m_len == 0) m_rgb = tbl[3*m_step +: 3];
          end
        end
      end else if (start && !bus.abort) begin
        m_run  = 1; m_t = 0; m_len = int'(bus.dwell) + 1; m_loop = bus.loop_mode;
        m_step = 0; m_rgb = tbl[2:0];
      end
    end
    #1;
    if (m_valid && !reset) begin
      check("model_busy", bus.busy, m_run);
      check("model_done", bus.done, m_done);
      check("model_step", bus.step_idx, m_step);
`ifndef RGB_SEQ_PWM_EN
      check("model_rgb", rgb_now(), m_rgb);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk) bus.button = 1'b1;
    @(negedge clk) bus.button = 1'b0;
  endtask

  int busy_cnt, done_cnt;

  initial begin
    reset            = 1'b1;
    bus.button       = 1'b0;
    bus.abort        = 1'b0;
    bus.loop_mode    = 1'b0;
    bus.dwell        = '0;
    bus.colour_table = TBL_STD;
    bus.duty         = '0;
    tick(2);
    check("reset_rgb", rgb_now(), 3'b000);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_step", bus.step_idx, 0);
    check("reset_done", bus.done, 1'b0);
    reset = 1'b0;
    tick(2);

`ifndef RGB_SEQ_PWM_EN
    // 1: one-shot, dwell=2
    bus.dwell = 4'd2; bus.loop_mode = 1'b0;
    press();
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) check("t1_red", rgb_now(), 3'b100);
      if (i == 2) check("t1_red_last", rgb_now(), 3'b100);
      if (i == 3) check("t1_green", rgb_now(), 3'b010);
      if (i == 6) check("t1_blue", rgb_now(), 3'b001);
      if (i == 9) begin
        check("t1_off", rgb_now(), 3'b000);
        check("t1_done", bus.done, 1'b1);
      end
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
      tick(1);
    end
    check("t1_busy_cycles", busy_cnt, 9);
    check("t1_done_pulses", done_cnt, 1);

    // 2: loop, dwell=0, abort during step 1
    bus.dwell = 4'd0; bus.loop_mode = 1'b1;
    press();
    check("t2_c0", {rgb_now(), 2'(bus.step_idx)}, {3'b100, 2'd0}); tick(1);
    check("t2_c1", {rgb_now(), 2'(bus.step_idx)}, {3'b010, 2'd1}); tick(1);
    check("t2_c2", {rgb_now(), 2'(bus.step_idx)}, {3'b001, 2'd2}); tick(1);
    check("t2_c3", {rgb_now(), 2'(bus.step_idx)}, {3'b100, 2'd0}); tick(1);
    check("t2_c4", {rgb_now(), 2'(bus.step_idx)}, {3'b010, 2'd1});
    bus.abort = 1'b1;
    tick(1);
    check("t2_abort_rgb", rgb_now(), 3'b000);
    check("t2_abort_busy", bus.busy, 1'b0);
    check("t2_abort_done", bus.done, 1'b0);
    bus.abort = 1'b0; bus.loop_mode = 1'b0;
    tick(3);

    // 3: held button, dwell=1
    bus.dwell = 4'd1;
    @(negedge clk) bus.button = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
    end
    bus.button = 1'b0;
    check("t3_busy_cycles", busy_cnt, 6);
    check("t3_done_pulses", done_cnt, 1);
    tick(2);

    // 4: dwell and table changed mid-run
    bus.dwell = 4'd2;
    press();
    bus.dwell = 4'd7;
    bus.colour_table = 9'b111_010_100;
    busy_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 3) check("t4_green", rgb_now(), 3'b010);
      if (i == 6) check("t4_white", rgb_now(), 3'b111);
      if (i == 9) check("t4_done", bus.done, 1'b1);
      busy_cnt += int'(bus.busy);
      tick(1);
    end
    check("t4_busy_cycles", busy_cnt, 9);
    bus.colour_table = TBL_STD;
    bus.dwell = 4'd2;
    tick(2);

    // 5: reset mid-run, then restart
    press();
    tick(3);
    check("t5_step1", {rgb_now(), 2'(bus.step_idx)}, {3'b010, 2'd1});
    #2 reset = 1'b1;
    #1;
    check("t5_rst_rgb", rgb_now(), 3'b000);
    check("t5_rst_busy", bus.busy, 1'b0);
    check("t5_rst_step", bus.step_idx, 0);
    check("t5_rst_done", bus.done, 1'b0);
    @(negedge clk) reset = 1'b0;
    press();
    check("t5_restart", {rgb_now(), 2'(bus.step_idx), bus.busy}, {3'b100, 2'd0, 1'b1});
    tick(12);
`else
    // 6: PWM dimming on a red-only looping sequence
    bus.colour_table = 9'b100_100_100;
    bus.dwell = 4'd15; bus.loop_mode = 1'b1; bus.duty = 4'd4;
    press();
    tick(2);
    busy_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      busy_cnt += int'(bus.red);
      tick(1);
    end
    check("t6_duty4_red", busy_cnt, 8);
    bus.duty = 4'd0;
    tick(2);
    busy_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      busy_cnt += int'(bus.red);
      tick(1);
    end
    check("t6_duty0_red", busy_cnt, 0);
    bus.abort = 1'b1;
    tick(1);
    check("t6_abort_busy", bus.busy, 1'b0);
    bus.abort = 1'b0;
    tick(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
